// File: rtl/line_triplet_feeder.sv
// Four-row ring buffer feeding sliding row triplets to the Sobel box.
// Optional triplet counter output enabled by FEEDER_STATS_EN.
module line_triplet_feeder #(
  parameter int WORDS_PER_LINE  = 64,
  parameter int LINES_PER_FRAME = 480,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data_valid,
  input  logic [63:0]      i_data,
  output logic             o_data_ack,
  output logic             o_line1_data_valid,
  output logic [63:0]      o_line1_data,
  input  logic             i_line1_data_ack,
  output logic             o_line2_data_valid,
  output logic [63:0]      o_line2_data,
  input  logic             i_line2_data_ack,
  output logic             o_line3_data_valid,
  output logic [63:0]      o_line3_data,
  input  logic             i_line3_data_ack,
  output logic             o_filter,
  input  logic             i_filter_done,
`ifdef FEEDER_STATS_EN
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_triplet_count
`else
  output logic             o_frame_done
`endif
);

  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam logic [WW-1:0] LAST_W =
    WW'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] N_ROWS =
    CNT_W'(LINES_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_T =
    CNT_W'(LINES_PER_FRAME - 3);

  typedef enum logic [1:0] {
    FILL,
    SEND,
    FILTER,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic [63:0]      mem [4*WORDS_PER_LINE];
  logic [1:0]       wr_buf;
  logic [1:0]       base;
  logic [1:0]       base1;
  logic [1:0]       base2;
  logic [WW-1:0]    wr_word;
  logic [WW-1:0]    rd_word;
  logic [WW-1:0]    rd_nx_word;
  logic [2:0]       rows_stored;
  logic [CNT_W-1:0] in_row;
  logic [CNT_W-1:0] out_row;
  logic             wr_en;
  logic             row_done;
  logic             go;
  logic             fire;
  logic             done_ok;
  logic             last_trip;
  logic             free_buf;
  logic             flush;
  logic             load;

  // Reset gates ack so the host sees no acceptance while held in reset.
  assign o_data_ack = i_rst
                    && (rows_stored != 3'd4)
                    && (in_row < N_ROWS);

  assign wr_en     = i_data_valid && o_data_ack;
  assign row_done  = wr_en && (wr_word == LAST_W);
  assign go        = (state == FILL)
                  && (rows_stored >= 3'd3);
  assign fire      = (state == SEND)
                  && i_line1_data_ack
                  && i_line2_data_ack
                  && i_line3_data_ack;
  assign done_ok   = (state == FILTER) && i_filter_done;
  assign last_trip = (out_row == LAST_T);
  assign free_buf  = done_ok && !last_trip;
  assign flush     = (state == FLUSH);

  assign o_line1_data_valid = (state == SEND);
  assign o_line2_data_valid = (state == SEND);
  assign o_line3_data_valid = (state == SEND);
  assign o_filter           = (state == FILTER);
  assign o_frame_done       = flush;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL: begin
        if (go) state_nx = SEND;
      end
      SEND: begin
        if (fire && (rd_word == LAST_W))
          state_nx = FILTER;
      end
      FILTER: begin
        if (done_ok)
          state_nx = last_trip ? FLUSH : FILL;
      end
      FLUSH: state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[{wr_buf, wr_word}] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_buf  <= '0;
      wr_word <= '0;
      in_row  <= '0;
    end else if (flush) begin
      wr_buf  <= '0;
      wr_word <= '0;
      in_row  <= '0;
    end else if (wr_en) begin
      wr_word <= wr_word + 1'b1;
      if (row_done) begin
        wr_buf <= wr_buf + 2'd1;
        in_row <= in_row + 1'b1;
      end
    end
  end

  // A row completing while a buffer is freed leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rows_stored <= '0;
    end else if (flush) begin
      rows_stored <= '0;
    end else if (row_done && !free_buf) begin
      rows_stored <= rows_stored + 3'd1;
    end else if (!row_done && free_buf) begin
      rows_stored <= rows_stored - 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      base    <= '0;
      rd_word <= '0;
      out_row <= '0;
    end else if (flush) begin
      base    <= '0;
      rd_word <= '0;
      out_row <= '0;
    end else begin
      if (fire)     rd_word <= rd_word + 1'b1;
      if (done_ok)  out_row <= out_row + 1'b1;
      if (free_buf) base    <= base + 2'd1;
    end
  end

  // Prefetch the next word so data is ready with valid.
  assign base1      = base + 2'd1;
  assign base2      = base + 2'd2;
  assign rd_nx_word = (state == SEND) ? rd_word + 1'b1 : '0;
  assign load       = go || (fire && (rd_word != LAST_W));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_line1_data <= '0;
      o_line2_data <= '0;
      o_line3_data <= '0;
    end else if (load) begin
      o_line1_data <= mem[{base,  rd_nx_word}];
      o_line2_data <= mem[{base1, rd_nx_word}];
      o_line3_data <= mem[{base2, rd_nx_word}];
    end
  end

`ifdef FEEDER_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_triplet_count <= '0;
    end else if (done_ok && (o_triplet_count != '1)) begin
      o_triplet_count <= o_triplet_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_line_triplet_feeder.sv
// Scoreboard bench for line_triplet_feeder (WORDS_PER_LINE=4, LINES_PER_FRAME=5).
// Stats checks compile only when FEEDER_STATS_EN is defined.
module tb_line_triplet_feeder;

  localparam int WPL = 4;
  localparam int LPF = 5;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_data_valid;
  logic [63:0]   i_data;
  logic          o_data_ack;
  logic          v1, v2, v3;
  logic [63:0]   d1, d2, d3;
  logic          a1, a2, a3;
  logic          o_filter;
  logic          i_filter_done;
  logic          o_frame_done;
`ifdef FEEDER_STATS_EN
  logic [CW-1:0] o_triplet_count;
`endif

  int checks = 0;
  int passes = 0;
  int frame_id = 0;
  logic [191:0] exp_q[$];

  always #5 clk = ~clk;

  line_triplet_feeder #(
    .WORDS_PER_LINE  (WPL),
    .LINES_PER_FRAME (LPF),
    .CNT_W           (CW)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst_n),
    .i_data_valid       (i_data_valid),
    .i_data             (i_data),
    .o_data_ack         (o_data_ack),
    .o_line1_data_valid (v1),
    .o_line1_data       (d1),
    .i_line1_data_ack   (a1),
    .o_line2_data_valid (v2),
    .o_line2_data       (d2),
    .i_line2_data_ack   (a2),
    .o_line3_data_valid (v3),
    .o_line3_data       (d3),
    .i_line3_data_ack   (a3),
    .o_filter           (o_filter),
    .i_filter_done      (i_filter_done),
`ifdef FEEDER_STATS_EN
    .o_frame_done       (o_frame_done),
    .o_triplet_count    (o_triplet_count)
`else
    .o_frame_done       (o_frame_done)
`endif
  );

  function automatic logic [63:0] pix(int f, int r, int w);
    return {8'hA5, 8'(f), 16'(r), 16'(w), 16'(r*16+w)};
  endfunction

  task automatic idle_inputs();
    i_data_valid  = 1'b0;
    i_data        = '0;
    a1            = 1'b1;
    a2            = 1'b1;
    a3            = 1'b1;
    i_filter_done = 1'b0;
  endtask

  // One frame: host feed, line sinks, filter responder and scoreboard.
  task automatic run_frame(input int host_div,
                           input int stall_pct,
                           input bit stray,
                           input int abort_at,
                           output bit aborted);
    int cyc = 0, hrow = 0, hword = 0, stored = 0;
    int trips = 0, fires = 0, wins = 0, fdone = 0;
    int fcnt = 0, row2_cyc = -1;
    bit first_v = 1'b1, prev_hold = 1'b0;
    bit prev_done = 1'b0, prev_filt = 1'b0, fin = 1'b0;
    bit xfer, fire, dacc, exp_ack, vok;
    logic [191:0] prev_d = '0, cur, exp;
    frame_id++;
    aborted = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cur = {d1, d2, d3};
      exp_ack = (stored < 4) && (hrow < LPF);
      checks++;
      if (o_data_ack !== exp_ack)
        $display("FAIL data_ack cyc %0d: got %b want %b", cyc, o_data_ack, exp_ack);
      else passes++;
      vok = (v1 === v2) && (v1 === v3)
         && (!v1 || (stored >= 3 && o_filter === 1'b0));
      checks++;
      if (!vok)
        $display("FAIL valid_state cyc %0d: v=%b%b%b filt=%b stored=%0d want >=3", cyc, v1, v2, v3, o_filter, stored);
      else passes++;
      if (prev_hold) begin
        checks++;
        if (v1 !== 1'b1 || cur !== prev_d)
          $display("FAIL hold cyc %0d: got v=%b %h want v=1 %h", cyc, v1, cur, prev_d);
        else passes++;
      end
      if (v1 === 1'b1 && first_v) begin
        first_v = 1'b0;
        checks++;
        if (cyc - row2_cyc !== 2)
          $display("FAIL latency: got %0d want 2", cyc - row2_cyc);
        else passes++;
      end
      if (prev_done) begin
        checks++;
        if (o_filter !== 1'b0)
          $display("FAIL filter_drop cyc %0d: got %b want 0", cyc, o_filter);
        else passes++;
      end
      if (o_filter === 1'b1 && !prev_filt) wins++;
      prev_filt = (o_filter === 1'b1);
      if (o_frame_done === 1'b1) begin
        fdone++;
        fin = 1'b1;
        checks++;
        if (trips !== LPF-2)
          $display("FAIL frame_done_at: got trips %0d want %0d", trips, LPF-2);
        else passes++;
      end
      if (fin) begin
        idle_inputs();
      end else begin
        i_data_valid = (cyc % host_div == 0);
        i_data = (hrow < LPF) ? pix(frame_id, hrow, hword)
                              : 64'hDEAD_BEEF_DEAD_BEEF;
        a1 = 1'b1;
        a2 = ($urandom_range(99) >= stall_pct);
        a3 = 1'b1;
        if (o_filter === 1'b1) begin
          fcnt++;
          i_filter_done = (fcnt == 5);
        end else begin
          fcnt = 0;
          i_filter_done = stray && ($urandom_range(3) == 0);
        end
        xfer = i_data_valid && (o_data_ack === 1'b1);
        fire = (v1 === 1'b1) && a1 && a2 && a3;
        dacc = i_filter_done && (o_filter === 1'b1);
        prev_hold = (v1 === 1'b1) && !fire;
        prev_d    = cur;
        prev_done = dacc;
        if (fire) begin
          fires++;
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL extra_word: got %h want none", cur);
          end else begin
            exp = exp_q.pop_front();
            if (cur !== exp)
              $display("FAIL line_data word %0d: got %h want %h", fires, cur, exp);
            else passes++;
          end
        end
        if (xfer) begin
          hword++;
          if (hword == WPL) begin
            hword = 0;
            hrow++;
            stored++;
            if (hrow == 3) row2_cyc = cyc;
            if (hrow >= 3)
              for (int w = 0; w < WPL; w++)
                exp_q.push_back({pix(frame_id, hrow-3, w),
                                 pix(frame_id, hrow-2, w),
                                 pix(frame_id, hrow-1, w)});
          end
        end
        if (dacc) begin
          trips++;
          if (trips < LPF-2) stored--;
        end
        if (abort_at > 0 && fires == abort_at) begin
          aborted = 1'b1;
          fin = 1'b1;
        end
      end
    end
    if (!aborted) begin
      idle_inputs();
      checks++;
      if (!fin) $display("FAIL timeout: got %0d cycles want frame_done", cyc);
      else passes++;
      checks++;
      if (wins !== LPF-2)
        $display("FAIL filter_windows: got %0d want %0d", wins, LPF-2);
      else passes++;
      checks++;
      if (exp_q.size() !== 0)
        $display("FAIL words_left: got %0d want 0", exp_q.size());
      else passes++;
      checks++;
      if (fdone !== 1)
        $display("FAIL frame_done_count: got %0d want 1", fdone);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ({o_data_ack, v1, v2, v3, o_filter, o_frame_done} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {o_data_ack, v1, v2, v3, o_filter, o_frame_done});
    else passes++;
    checks++;
    if ({d1, d2, d3} !== 192'b0)
      $display("FAIL reset_data: got %h want 0", {d1, d2, d3});
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_data_ack !== 1'b1 || v1 !== 1'b0)
      $display("FAIL after_reset: got ack %b v %b want 1 0", o_data_ack, v1);
    else passes++;
  endtask

  task automatic test_frame();
    bit ab;
    run_frame(1, 0, 1'b0, 0, ab);
  endtask

  task automatic test_back_to_back();
    bit ab;
    run_frame(1, 0, 1'b0, 0, ab);
  endtask

  task automatic test_line_stall();
    bit ab;
    run_frame(1, 30, 1'b0, 0, ab);
  endtask

  task automatic test_throttle();
    bit ab;
    run_frame(3, 0, 1'b1, 0, ab);
  endtask

  task automatic test_mid_reset();
    bit ab;
    run_frame(1, 0, 1'b0, 2, ab);
    @(posedge clk);
    #2;
    checks++;
    if (v1 !== 1'b1)
      $display("FAIL mid_send: got v %b want 1", v1);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_data_ack, v1, v2, v3, o_filter, o_frame_done} !== 6'b0)
      $display("FAIL async_reset_ctrl: got %b want 000000", {o_data_ack, v1, v2, v3, o_filter, o_frame_done});
    else passes++;
    checks++;
    if ({d1, d2, d3} !== 192'b0)
      $display("FAIL async_reset_data: got %h want 0", {d1, d2, d3});
    else passes++;
    idle_inputs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(1, 0, 1'b0, 0, ab);
  endtask

`ifdef FEEDER_STATS_EN
  task automatic test_stats();
    bit ab;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_triplet_count !== '0)
      $display("FAIL stats_reset: got %0d want 0", o_triplet_count);
    else passes++;
    run_frame(1, 0, 1'b0, 0, ab);
    @(negedge clk);
    checks++;
    if (o_triplet_count !== CW'(LPF-2))
      $display("FAIL stats_frame: got %0d want %0d", o_triplet_count, LPF-2);
    else passes++;
    i_filter_done = 1'b1;
    repeat (3) @(negedge clk);
    i_filter_done = 1'b0;
    @(negedge clk);
    checks++;
    if (o_triplet_count !== CW'(LPF-2))
      $display("FAIL stats_stray: got %0d want %0d", o_triplet_count, LPF-2);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_line_stall();
    test_throttle();
    test_mid_reset();
`ifdef FEEDER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
